// File: rtl/if_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Holds the fetch PC, presents it to a combinational-read instruction ROM,
// and captures the returned word (with its PC+4) for the decode stage.
// Redirects from ID (jr or taken branch) squash the word fetched in the
// redirect cycle, so there is no branch delay slot.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        PC_jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc_if,
  output logic [31:0] instr_id,
  output logic [31:0] pc_plus4_id,
  output logic        valid_id
);

  logic [31:0] pc_r;
  logic [31:0] instr_id_r;
  logic [31:0] pc_plus4_id_r;
  logic        valid_id_r;

  logic [31:0] pc_plus4_s;
  logic [31:0] redirect_target_s;
  logic        redirect_s;

  // Instruction words are 4-byte aligned; low address bits of a target are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Sequential PC increment and redirect target selection (jr wins over branch).
  always_comb begin
    pc_plus4_s        = 32'h0000_0000;
    redirect_target_s = 32'h0000_0000;
    redirect_s        = 1'b0;
    pc_plus4_s        = pc_r + 32'd4;
    redirect_s        = PC_jump | branch_taken;
    if (PC_jump) begin
      redirect_target_s = word_align(jump_target);
    end else begin
      redirect_target_s = word_align(branch_target);
    end
  end

  // PC and IF/ID update: reset, then stall hold, then redirect, then flush, then normal fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      instr_id_r    <= NOP_INSTR;
      pc_plus4_id_r <= 32'h0000_0000;
      valid_id_r    <= 1'b0;
    end else if (stall) begin
      // The ID instruction is re-presented when stall drops, so any
      // redirect/flush seen now will be raised again then.
      pc_r          <= pc_r;
      instr_id_r    <= instr_id_r;
      pc_plus4_id_r <= pc_plus4_id_r;
      valid_id_r    <= valid_id_r;
    end else if (redirect_s) begin
      pc_r          <= redirect_target_s;
      instr_id_r    <= NOP_INSTR;
      pc_plus4_id_r <= 32'h0000_0000;
      valid_id_r    <= 1'b0;
    end else if (flush) begin
      pc_r          <= pc_plus4_s;
      instr_id_r    <= NOP_INSTR;
      pc_plus4_id_r <= 32'h0000_0000;
      valid_id_r    <= 1'b0;
    end else begin
      pc_r          <= pc_plus4_s;
      instr_id_r    <= imem_data;
      pc_plus4_id_r <= pc_plus4_s;
      valid_id_r    <= 1'b1;
    end
  end

  assign imem_addr   = pc_r;
  assign pc_if       = pc_r;
  assign instr_id    = instr_id_r;
  assign pc_plus4_id = pc_plus4_id_r;
  assign valid_id    = valid_id_r;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by a
// randomized phase, all compared against a behavioural fetch model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        PC_jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_if;
  logic [31:0] instr_id;
  logic [31:0] pc_plus4_id;
  logic        valid_id;

  int checks;
  int failures;

  // Behavioural model state.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;

  if_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .PC_jump      (PC_jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .pc_if        (pc_if),
    .instr_id     (instr_id),
    .pc_plus4_id  (pc_plus4_id),
    .valid_id     (valid_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word index i holds 32'h1000 + i.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h0000_1000 + (addr >> 2);
  endfunction

  assign imem_data = rom_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_edge();
    logic [31:0] tgt;
    if (rst) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = 32'd0; m_valid = 1'b0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (PC_jump || branch_taken) begin
      tgt = PC_jump ? jump_target : branch_target;
      m_pc = tgt & 32'hFFFF_FFFC;
      m_instr = NOP_INSTR; m_pc4 = 32'd0; m_valid = 1'b0;
    end else if (flush) begin
      m_pc = m_pc + 32'd4;
      m_instr = NOP_INSTR; m_pc4 = 32'd0; m_valid = 1'b0;
    end else begin
      m_instr = rom_word(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    pc_if,       m_pc);
    check({tag, ".addr"},  imem_addr,   m_pc);
    check({tag, ".instr"}, instr_id,    m_instr);
    check({tag, ".pc4"},   pc_plus4_id, m_pc4);
    check({tag, ".valid"}, {31'd0, valid_id}, {31'd0, m_valid});
  endtask

  // One clock edge: model first, then sample the DUT 1 time unit after the edge.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    checks = 0; failures = 0;
    m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; PC_jump = 1'b0; branch_taken = 1'b0;
    jump_target = 32'd0; branch_target = 32'd0;

    // Reset.
    tick("rst0");
    tick("rst1");
    check("rst_addr",  imem_addr, 32'h0000_0000);
    check("rst_valid", {31'd0, valid_id}, 32'd0);
    check("rst_pc4",   pc_plus4_id, 32'd0);
    rst = 1'b0;

    // Free run: first fetched word lands on instr_id one cycle later.
    tick("run0");
    check("run0_instr", instr_id, 32'h0000_1000);
    check("run0_pc4",   pc_plus4_id, 32'd4);
    check("run0_valid", {31'd0, valid_id}, 32'd1);
    tick("run1");
    check("run1_pc", pc_if, 32'd8);

    // Stall for three cycles at pc=8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check("stall_pc",    pc_if,    32'd8);
      check("stall_instr", instr_id, 32'h0000_1001);
    end
    stall = 1'b0;
    tick("unstall");
    check("unstall_instr", instr_id, 32'h0000_1002);
    check("unstall_pc",    pc_if,    32'd12);
    tick("run2");

    // jr to unaligned target at pc=16.
    check("pre_jump_pc", pc_if, 32'd16);
    PC_jump = 1'b1; jump_target = 32'h0000_0043;
    tick("jump");
    check("jump_pc",    pc_if,    32'h0000_0040);
    check("jump_instr", instr_id, NOP_INSTR);
    check("jump_valid", {31'd0, valid_id}, 32'd0);
    PC_jump = 1'b0;
    tick("post_jump");
    check("post_jump_instr", instr_id, 32'h0000_1010);

    // jr and branch together: jr wins; flush also asserted.
    PC_jump = 1'b1; jump_target = 32'h0000_0080;
    branch_taken = 1'b1; branch_target = 32'h0000_00C0; flush = 1'b1;
    tick("both");
    check("both_pc", pc_if, 32'h0000_0080);
    PC_jump = 1'b0; flush = 1'b0;
    branch_target = 32'h0000_0200;

    // Back-to-back redirect (branch still high) keeps IF/ID a bubble; then stall blocks it.
    tick("b2b");
    check("b2b_pc",    pc_if, 32'h0000_0200);
    check("b2b_valid", {31'd0, valid_id}, 32'd0);
    branch_taken = 1'b0;
    tick("run3");
    tick("run4");
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0300;
    tick("stall_br");
    check("stall_br_pc",    pc_if,    32'h0000_0208);
    check("stall_br_instr", instr_id, 32'h0000_1081);
    stall = 1'b0;
    tick("release_br");
    check("release_br_pc",    pc_if,    32'h0000_0300);
    check("release_br_valid", {31'd0, valid_id}, 32'd0);
    branch_taken = 1'b0;

    // Redirect to the current pc: same pc reloaded, IF/ID squashed.
    tick("run5");
    PC_jump = 1'b1; jump_target = pc_if;
    tick("self_jump");
    check("self_jump_pc",    pc_if, 32'h0000_0304);
    check("self_jump_valid", {31'd0, valid_id}, 32'd0);
    PC_jump = 1'b0;

    // Flush alone.
    tick("run6");
    flush = 1'b1;
    tick("flush");
    check("flush_pc",    pc_if, 32'h0000_030C);
    check("flush_instr", instr_id, NOP_INSTR);
    flush = 1'b0;

    // Wrap: pc 32'hFFFF_FFFC + 4 = 0.
    PC_jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    tick("to_top");
    check("to_top_pc", pc_if, 32'hFFFF_FFFC);
    PC_jump = 1'b0;
    tick("wrap");
    check("wrap_pc",    pc_if,       32'h0000_0000);
    check("wrap_pc4",   pc_plus4_id, 32'h0000_0000);
    check("wrap_instr", instr_id,    32'h4000_0FFF);

    // Reset during a stall.
    tick("run7");
    stall = 1'b1;
    tick("pre_rst_stall");
    rst = 1'b1;
    tick("rst_stall");
    check("rst_stall_pc",    pc_if, RESET_PC);
    check("rst_stall_valid", {31'd0, valid_id}, 32'd0);
    rst = 1'b0; stall = 1'b0;

    // Randomized phase against the model.
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 49) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 5) == 0);
      PC_jump       = ($urandom_range(0, 7) == 0);
      branch_taken  = ($urandom_range(0, 6) == 0);
      jump_target   = $urandom;
      branch_target = $urandom;
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Holds the PC, drives the instruction-memory address, and captures the fetched word into IF/ID.
- The ID-stage controller decodes opcode/func from `instr_id`.
- Accepts redirects from ID (jr via `PC_jump`, branches), and stall/flush from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on bubble/squash (sll $0,$0,0).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hazard unit: hold PC and IF/ID contents
- flush  input  1  hazard unit: load bubble into IF/ID this cycle
- PC_jump  input  1  from controller: jr in ID, redirect to jump_target
- jump_target  input  32  jr target (rs value) from ID
- branch_taken  input  1  taken beq/bne resolved in ID
- branch_target  input  32  branch target from ID
- imem_addr  output  32  instruction memory address (= pc), combinational-read ROM
- imem_data  input  32  instruction word at imem_addr, same cycle
- pc_if  output  32  current fetch PC
- instr_id  output  32  IF/ID instruction, feeds opcode/func decode
- pc_plus4_id  output  32  IF/ID PC+4 of instr_id
- valid_id  output  1  1 = instr_id is a real fetched instruction, 0 = bubble

Behaviour:
- Reset (rst=1 at edge, overrides everything):
  - pc <= RESET_PC, instr_id <= NOP_INSTR, pc_plus4_id <= 0, valid_id <= 0.
  - rst asserted mid-stall or mid-redirect discards all pending state.
- imem_addr = pc, combinational. Fetch latency: a word addressed in cycle N appears on instr_id in cycle N+1.
- PC arithmetic:
  - pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - Redirect targets have bits [1:0] forced to 2'b00 before loading.
- No branch delay slot: a redirect squashes the word fetched in the redirect cycle.
- Per-edge priority, highest first:
  1. rst.
  2. stall=1: pc, instr_id, pc_plus4_id and valid_id all hold. PC_jump, branch_taken and flush are ignored, because the ID instruction is re-presented once stall drops.
  3. Redirect (PC_jump=1 or branch_taken=1):
     - pc <= target. PC_jump wins if both are asserted.
     - IF/ID <= bubble: instr_id=NOP_INSTR, valid_id=0, pc_plus4_id=0.
  4. flush=1: pc <= pc+4, IF/ID <= bubble.
  5. Normal: pc <= pc+4, instr_id <= imem_data, pc_plus4_id <= pc+4, valid_id <= 1.
- Redirect and flush asserted together: redirect applies. The IF/ID result is a bubble either way.
- Back-to-back redirects on consecutive cycles: each is honoured, and IF/ID stays a bubble.
- Redirect to the current pc value is legal. pc reloads the same value and IF/ID is still squashed.
- No combinational path from any input to instr_id, pc_plus4_id or valid_id. imem_addr depends only on the pc register.

Test Plan:
- Reset then free-run with ROM[i]=32'h1000+i:
  - Cycle 1 after reset: imem_addr=0, valid_id=0.
  - Cycle 2: instr_id=32'h1000, pc_plus4_id=4, valid_id=1.
  - Continues sequentially.
- stall high for 3 cycles at pc=8: pc stays 8, instr_id holds ROM[1] for all 3 cycles. On release, the next edge loads ROM[2] and pc=12.
- PC_jump=1, jump_target=32'h0000_0043 at pc=16:
  - Next cycle: pc=32'h40, instr_id=NOP, valid_id=0.
  - Following cycle: instr_id=ROM[16].
- PC_jump=1 and branch_taken=1 together, targets 0x80 and 0xC0: pc=0x80 next cycle.
- stall=1 with branch_taken=1, target 0x200: pc unchanged and IF/ID unchanged. Drop stall with branch_taken still 1: pc=0x200 and a bubble is loaded.
- Wrap: set pc to 32'hFFFF_FFFC via jump_target, free-run one cycle: pc=0 and pc_plus4_id=0. Then assert rst during a stall: pc=RESET_PC and valid_id=0.
